// File: rtl/serial_adder.sv
// serial_adder
//   Digit-serial adder. Operands are accepted in IDLE, added DIGIT bits per
//   cycle from the least significant end in BUSY, and the result is held in
//   DONE until the consumer takes it.
//
// Parameters
//   WIDTH  operand / sum width in bits (2..64)
//   DIGIT  bits added per cycle; must divide WIDTH exactly
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   a, b and cin are presented
//   in_ready   block can accept operands (registered, high only in IDLE)
//   a, b       operands
//   cin        carry-in
//   out_valid  result available (registered, high only in DONE)
//   out_ready  consumer takes the result
//   sum        (a+b+cin) mod 2^WIDTH, holds the last result outside DONE
//   cout       unsigned carry-out
//   overflow   two's-complement overflow

module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG + 1);
  localparam int DW   = DIGIT + 1;

  generate
    if (WIDTH < 2 || WIDTH > 64 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_adder: WIDTH must be 2..64 and DIGIT must divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last_digit;

  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] result;
  logic             carry_into_msb;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;

  assign last_digit = (cnt == CW'(NDIG - 1));

  // One digit of the addition, carry-out in the top bit.
  assign dsum = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + DW'(carry);

  // result is the full sum as it will look once the current digit is shifted
  // in; on the last digit it is the final answer.
  generate
    if (NDIG == 1) begin : g_single
      assign result = dsum[DIGIT-1:0];
    end else begin : g_shift
      // Digits produced so far, filled from the MSB end.
      logic [WIDTH-DIGIT-1:0] acc;

      assign result = {dsum[DIGIT-1:0], acc};

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc <= '0;
        end else if (state == IDLE && in_valid) begin
          acc <= '0;
        end else if (state == BUSY) begin
          acc <= result[WIDTH-1:DIGIT];
        end
      end
    end
  endgenerate

  // On the last digit the low bits of a_sh/b_sh are the operand MSBs, so the
  // carry into the MSB is recovered from the MSB sum bit: s = a ^ b ^ c.
  assign carry_into_msb = result[WIDTH-1] ^ a_sh[DIGIT-1] ^ b_sh[DIGIT-1];

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: state_next gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)   state_next = BUSY;
      BUSY:    if (last_digit) state_next = DONE;
      DONE:    if (out_ready)  state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh        <= '0;
      b_sh        <= '0;
      carry       <= 1'b0;
      cnt         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      // Handshake flags are registered copies of the next state.
      in_ready_q  <= (state_next == IDLE);
      out_valid_q <= (state_next == DONE);

      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        BUSY: begin
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          carry <= dsum[DIGIT];
          cnt   <= cnt + CW'(1);
          // Output registers change only when a complete result exists, so
          // a partial sum is never visible.
          if (last_digit) begin
            sum_q  <= result;
            cout_q <= dsum[DIGIT];
            ovf_q  <= carry_into_msb ^ dsum[DIGIT];
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
//   Drives three serial_adder instances (8/1, 8/4, 4/1) with shared operands
//   and handshakes, and compares every result, flag and latency with an
//   arithmetic reference model.

module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic       cin;
  logic [7:0] a;
  logic [7:0] b;

  logic [2:0] rdy;
  logic [2:0] vld;
  logic [2:0] co;
  logic [2:0] ov;
  logic [7:0] sum8;
  logic [7:0] sum84;
  logic [3:0] sum4;

  int n_checks = 0;
  int n_errors = 0;

  localparam int    W   [3] = '{8, 8, 4};
  localparam int    LAT [3] = '{8, 2, 4};
  localparam string NAME[3] = '{"w8d1", "w8d4", "w4d1"};

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
    .a(a), .b(b), .cin(cin), .out_valid(vld[0]), .out_ready(out_ready),
    .sum(sum8), .cout(co[0]), .overflow(ov[0])
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
    .a(a), .b(b), .cin(cin), .out_valid(vld[1]), .out_ready(out_ready),
    .sum(sum84), .cout(co[1]), .overflow(ov[1])
  );

  serial_adder #(.WIDTH(4), .DIGIT(1)) u_w4d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
    .a(a[3:0]), .b(b[3:0]), .cin(cin), .out_valid(vld[2]), .out_ready(out_ready),
    .sum(sum4), .cout(co[2]), .overflow(ov[2])
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: unsigned sum by plain integer addition, overflow by checking
  // whether the signed sum leaves the representable range.
  function automatic void model(input int w, input longint ua_in, input longint ub_in,
                                input int c, output longint s, output longint cy,
                                output longint ovf);
    longint mask;
    longint half;
    longint ua;
    longint ub;
    longint tot;
    longint sa;
    longint sb;
    longint st;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = ua_in & mask;
    ub   = ub_in & mask;
    tot  = ua + ub + c;
    s    = tot & mask;
    cy   = tot >> w;
    sa   = (ua >= half) ? ua - 2 * half : ua;
    sb   = (ub >= half) ? ub - 2 * half : ub;
    st   = sa + sb + c;
    ovf  = (st >= half || st < -half) ? 1 : 0;
  endfunction

  function automatic longint sum_of(input int i);
    case (i)
      0:       return longint'(sum8);
      1:       return longint'(sum84);
      default: return longint'(sum4);
    endcase
  endfunction

  // One transaction on all three instances. hold > 0 adds junk in_valid
  // pulses during BUSY/DONE and that many extra DONE cycles with out_ready=0.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                        input int hold);
    longint es[3];
    longint ec[3];
    longint eo[3];
    int     lat[3];
    for (int i = 0; i < 3; i++) begin
      model(W[i], longint'(ta), longint'(tb_v), int'(tc), es[i], ec[i], eo[i]);
      lat[i] = -1;
    end
    check("in_ready_idle", longint'(rdy), 3'b111);

    a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    check("in_ready_busy", longint'(rdy), 3'b000);

    for (int cyc = 1; cyc <= 20 && (lat[0] < 0 || lat[1] < 0 || lat[2] < 0); cyc++) begin
      if (hold > 0) begin
        in_valid = 1'($urandom); a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      end
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++)
        if (vld[i] && lat[i] < 0) lat[i] = cyc;
    end
    for (int i = 0; i < 3; i++)
      check($sformatf("latency_%s", NAME[i]), longint'(lat[i]), longint'(LAT[i]));

    for (int k = 0; k < hold; k++) begin
      in_valid = 1'($urandom); a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      @(posedge clk); #1;
      check("done_hold_valid", longint'({vld, rdy}), 6'b111_000);
    end
    in_valid = 1'b0;

    for (int i = 0; i < 3; i++) begin
      check($sformatf("sum_%s", NAME[i]),  sum_of(i),        es[i]);
      check($sformatf("cout_%s", NAME[i]), longint'(co[i]),  ec[i]);
      check($sformatf("ovf_%s", NAME[i]),  longint'(ov[i]),  eo[i]);
    end

    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_after_handoff", longint'(vld), 3'b000);
    check("in_ready_after_handoff", longint'(rdy), 3'b111);
    check("sum_held_idle", longint'(sum8), es[0]);
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("reset_in_ready", longint'(rdy), 3'b111);
    check("reset_out_valid", longint'(vld), 3'b000);
    check("reset_sum8", longint'(sum8), 0);
    check("reset_cout", longint'(co), 0);
    check("reset_ovf", longint'(ov), 0);
    #9 rst_n = 1'b1;

    // Accepted on the first rising edge after release.
    run_op(8'hFF, 8'h01, 1'b0, 0);
    run_op(8'h00, 8'h00, 1'b1, 0);
    run_op(8'hF0, 8'h1F, 1'b1, 0);
    run_op(8'hFF, 8'hFF, 1'b1, 0);
    run_op(8'h80, 8'h80, 1'b0, 0);
    run_op(8'h12, 8'h34, 1'b0, 5);
    run_op(8'h7F, 8'h01, 1'b0, 2);

    // Reset three cycles into BUSY while sum8 still shows 8'h80.
    a = 8'h3C; b = 8'h0F; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midop_reset_in_ready", longint'(rdy), 3'b111);
    check("midop_reset_out_valid", longint'(vld), 3'b000);
    check("midop_reset_sum8", longint'(sum8), 0);
    check("midop_reset_cout", longint'(co), 0);
    #2 rst_n = 1'b1;
    run_op(8'h3C, 8'h0F, 1'b1, 0);

    for (int n = 0; n < 40; n++)
      run_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int c = 0; c < 2; c++)
          run_op({4'($urandom), ia[3:0]}, {4'($urandom), ib[3:0]}, c[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
